// File: rtl/buffer_pkg.sv
// ============================================================================
// Module   : buffer_pkg
// Purpose  : Mode encodings and window-address helper for window_line_buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package buffer_pkg;

   localparam logic MODE_ADDR   = 1'b0;
   localparam logic MODE_WINDOW = 1'b1;

   // Age offset 0 is the newest stored sample, which sits just behind wr_ptr.
   function automatic logic [31:0] window_addr(input logic [31:0] wr_ptr,
                                               input logic [31:0] offset,
                                               input logic [31:0] depth);
      return (wr_ptr - 32'd1 - offset) & (depth - 32'd1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/buffer_read_port.sv
// ============================================================================
// Module   : buffer_read_port
// Purpose  : One registered read port: address select, valid compare and
//            optional same-cycle write bypass (BUFFER_BYPASS_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module buffer_read_port
   import buffer_pkg::*;
#(
   parameter int DataWidth = 8,
   parameter int Depth     = 16,
   parameter int AddrWidth = 4
) (
   input  logic                 clk,
   input  logic                 aclr_n,
   input  logic                 mode_i,
   input  logic [AddrWidth-1:0] r_addr_i,
   input  logic [AddrWidth-1:0] wr_ptr_i,
   input  logic [AddrWidth:0]   count_i,
   input  logic                 accept_i,
   input  logic [DataWidth-1:0] data_in_i,
   output logic [AddrWidth-1:0] mem_addr_o,
   input  logic [DataWidth-1:0] mem_data_i,
   output logic [DataWidth-1:0] data_o,
   output logic                 valid_o
);

   logic [DataWidth-1:0] data_d;
   logic [DataWidth-1:0] data_q;
   logic                 valid_d;
   logic                 valid_q;

   always_comb begin
      mem_addr_o = r_addr_i;
      if (mode_i == MODE_WINDOW) begin
         mem_addr_o = AddrWidth'(window_addr(32'(wr_ptr_i), 32'(r_addr_i), 32'(Depth)));
      end
   end

`ifdef BUFFER_BYPASS_EN
   always_comb begin
      data_d  = mem_data_i;
      valid_d = ({1'b0, r_addr_i} < count_i);
      if ((mode_i == MODE_ADDR) && accept_i && (mem_addr_o == wr_ptr_i)) begin
         data_d  = data_in_i;
         valid_d = 1'b1;
      end
   end
`else
   logic bypass_unused;
   assign bypass_unused = accept_i ^ (^data_in_i);

   always_comb begin
      data_d  = mem_data_i;
      valid_d = ({1'b0, r_addr_i} < count_i);
   end
`endif

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/window_line_buffer.sv
// ============================================================================
// Module   : window_line_buffer
// Purpose  : Circular sample buffer, addressed or sliding-window mode, with
//            NumPorts registered read ports. Option macro: BUFFER_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module window_line_buffer
   import buffer_pkg::*;
#(
   parameter int DataWidth = 8,
   parameter int Depth     = 16,
   parameter int AddrWidth = 4,
   parameter int NumPorts  = 3
) (
   input  logic                           clk,
   input  logic                           aclr_n,
   input  logic                           flush,
   input  logic                           Mode,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DataWidth-1:0]           DataIn,
   input  logic [NumPorts*AddrWidth-1:0]  R_Addr,
   output logic [NumPorts*DataWidth-1:0]  DataOut,
   output logic [NumPorts-1:0]            out_valid,
   output logic [AddrWidth:0]             Count,
   output logic                           Full
);

   localparam logic [AddrWidth:0] DEPTH_COUNT = (AddrWidth+1)'(Depth);

   logic [DataWidth-1:0] mem_q [Depth];
   logic [AddrWidth-1:0] wr_ptr_d;
   logic [AddrWidth-1:0] wr_ptr_q;
   logic [AddrWidth:0]   count_d;
   logic [AddrWidth:0]   count_q;
   logic                 accept;

   assign Full     = (count_q == DEPTH_COUNT);
   assign Count    = count_q;
   assign in_ready = !flush && (Mode || !Full);
   assign accept   = in_valid && in_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         count_d  = '0;
      end else if (accept) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         if (!Full) begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately unreset; out_valid keeps stale words from escaping.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_q[wr_ptr_q] <= DataIn;
      end
   end

   generate
      for (genvar k = 0; k < NumPorts; k++) begin : g_port
         logic [AddrWidth-1:0] mem_addr;

         buffer_read_port #(
            .DataWidth (DataWidth),
            .Depth     (Depth),
            .AddrWidth (AddrWidth)
         ) u_port (
            .clk        (clk),
            .aclr_n     (aclr_n),
            .mode_i     (Mode),
            .r_addr_i   (R_Addr[k*AddrWidth +: AddrWidth]),
            .wr_ptr_i   (wr_ptr_q),
            .count_i    (count_q),
            .accept_i   (accept),
            .data_in_i  (DataIn),
            .mem_addr_o (mem_addr),
            .mem_data_i (mem_q[mem_addr]),
            .data_o     (DataOut[k*DataWidth +: DataWidth]),
            .valid_o    (out_valid[k])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_window_line_buffer.sv
// ============================================================================
// Module   : tb_window_line_buffer
// Purpose  : Self-checking bench for window_line_buffer against a queue-based
//            reference model. Honours BUFFER_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_window_line_buffer;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int NP    = 3;

   logic             clk = 1'b0;
   logic             aclr_n;
   logic             flush;
   logic             Mode;
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    DataIn;
   logic [NP*AW-1:0] R_Addr;
   logic [NP*DW-1:0] DataOut;
   logic [NP-1:0]    out_valid;
   logic [AW:0]      Count;
   logic             Full;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: samples accepted since the last clear, oldest first.
   int            hist[$];
   int            m_total;
   logic [DW-1:0] m_mem [DEPTH];
   logic [DW-1:0] exp_data  [NP];
   logic          exp_valid [NP];

   window_line_buffer #(
      .DataWidth (DW),
      .Depth     (DEPTH),
      .AddrWidth (AW),
      .NumPorts  (NP)
   ) dut (
      .clk       (clk),
      .aclr_n    (aclr_n),
      .flush     (flush),
      .Mode      (Mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .DataIn    (DataIn),
      .R_Addr    (R_Addr),
      .DataOut   (DataOut),
      .out_valid (out_valid),
      .Count     (Count),
      .Full      (Full)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic m_ready();
      return !flush && (Mode || (hist.size() < DEPTH));
   endfunction

   task automatic model_clear();
      hist.delete();
      m_total = 0;
   endtask

   task automatic set_addr(input int k, input int a);
      R_Addr[k*AW +: AW] = AW'(a);
   endtask

   // Predicts the next outputs from the current inputs, advances one edge.
   task automatic tick();
      int   cnt;
      int   pos;
      int   a;
      int   s;
      logic acc;
      cnt = hist.size();
      pos = m_total % DEPTH;
      acc = in_valid && m_ready();
      for (int k = 0; k < NP; k++) begin
         a = int'(R_Addr[k*AW +: AW]);
         exp_valid[k] = (a < cnt);
         exp_data[k]  = 'x;
         if (!Mode) begin
            exp_data[k] = m_mem[a];
         end else if (a < cnt) begin
            s = hist[cnt-1-a];
            exp_data[k] = DW'(s);
         end
`ifdef BUFFER_BYPASS_EN
         if (!Mode && acc && (a == pos)) begin
            exp_data[k]  = DataIn;
            exp_valid[k] = 1'b1;
         end
`endif
      end
      if (flush) begin
         model_clear();
      end else if (acc) begin
         m_mem[pos] = DataIn;
         hist.push_back(int'(DataIn));
         if (hist.size() > DEPTH) void'(hist.pop_front());
         m_total++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_flush();
      flush    = 1'b1;
      in_valid = 1'b0;
      tick();
      flush = 1'b0;
   endtask

   task automatic write_seq(input int first, input int n);
      in_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         DataIn = DW'(first + i);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      aclr_n   = 1'b0;
      flush    = 1'b0;
      Mode     = 1'b0;
      in_valid = 1'b0;
      DataIn   = '0;
      R_Addr   = '0;
      model_clear();
      #3;
      n_checks++;
      if ({Count, Full, DataOut, out_valid} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: Count=%0d Full=%b DataOut=%h out_valid=%b, required all zero",
                  Count, Full, DataOut, out_valid);
      end
      @(negedge clk);
      aclr_n = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic test_reset_midstream();
      Mode = 1'b0;
      R_Addr = '0;
      write_seq(1, 7);
      tick();
      n_checks++;
      if ((Count !== 5'd7) || (out_valid !== 3'b111) || (DataOut[DW-1:0] !== 8'd1)) begin
         n_fail++;
         $display("FAIL pre_reset: Count=%0d out_valid=%b DataOut0=%0d, required 7/111/1",
                  Count, out_valid, DataOut[DW-1:0]);
      end
      in_valid = 1'b1;
      DataIn   = 8'h77;
      #2;
      aclr_n = 1'b0;
      #1;
      n_checks++;
      if ((Count !== '0) || (Full !== 1'b0) || (DataOut !== '0) || (out_valid !== 3'b000)) begin
         n_fail++;
         $display("FAIL midstream_reset: Count=%0d Full=%b DataOut=%h out_valid=%b, required 0/0/0/000",
                  Count, Full, DataOut, out_valid);
      end
      in_valid = 1'b0;
      model_clear();
      @(negedge clk);
      aclr_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_mode0_fill();
      do_flush();
      Mode = 1'b0;
      R_Addr = '0;
      in_valid = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         DataIn = DW'(i);
         #1;
         if (i == 17) begin
            n_checks++;
            if ((in_ready !== 1'b0) || (Full !== 1'b1)) begin
               n_fail++;
               $display("FAIL fill_full: in_ready=%b Full=%b, required 0/1", in_ready, Full);
            end
         end
         tick();
      end
      in_valid = 1'b0;
      set_addr(2, 15);
      set_addr(1, 5);
      set_addr(0, 0);
      tick();
      n_checks++;
      if ((DataOut !== {8'd16, 8'd6, 8'd1}) || (out_valid !== 3'b111) || (Count !== 5'd16)) begin
         n_fail++;
         $display("FAIL fill_read: DataOut=%h out_valid=%b Count=%0d, required 100601/111/16",
                  DataOut, out_valid, Count);
      end
   endtask

   task automatic test_mode1_slide();
      do_flush();
      Mode = 1'b1;
      write_seq(1, 20);
      set_addr(2, 2);
      set_addr(1, 1);
      set_addr(0, 0);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL slide_ready: in_ready=%b required 1", in_ready);
      end
      tick();
      n_checks++;
      if ((DataOut !== {8'd18, 8'd19, 8'd20}) || (Count !== 5'd16) || (Full !== 1'b1)) begin
         n_fail++;
         $display("FAIL slide_read: DataOut=%h Count=%0d Full=%b, required 121314/16/1",
                  DataOut, Count, Full);
      end
      set_addr(0, 15);
      tick();
      n_checks++;
      if ((DataOut[DW-1:0] !== 8'd5) || (out_valid[0] !== 1'b1)) begin
         n_fail++;
         $display("FAIL slide_oldest: DataOut0=%0d valid0=%b, required 5/1",
                  DataOut[DW-1:0], out_valid[0]);
      end
   endtask

   task automatic test_partial_window();
      do_flush();
      Mode = 1'b1;
      write_seq(1, 2);
      set_addr(2, 2);
      set_addr(1, 1);
      set_addr(0, 0);
      tick();
      n_checks++;
      if ((out_valid !== 3'b011) || (DataOut[DW-1:0] !== 8'd2) || (DataOut[DW +: DW] !== 8'd1)) begin
         n_fail++;
         $display("FAIL partial_window: out_valid=%b port0=%0d port1=%0d, required 011/2/1",
                  out_valid, DataOut[DW-1:0], DataOut[DW +: DW]);
      end
   endtask

   task automatic test_bypass();
      do_flush();
      Mode = 1'b0;
      R_Addr = '0;
      write_seq(8'h10, 3);
      set_addr(0, 3);
      set_addr(1, 0);
      set_addr(2, 1);
      in_valid = 1'b1;
      DataIn   = 8'hAA;
      tick();
      in_valid = 1'b0;
`ifdef BUFFER_BYPASS_EN
      n_checks++;
      if ((DataOut[DW-1:0] !== 8'hAA) || (out_valid[0] !== 1'b1)) begin
         n_fail++;
         $display("FAIL bypass_hit: DataOut0=%h valid0=%b, required aa/1",
                  DataOut[DW-1:0], out_valid[0]);
      end
`else
      n_checks++;
      if (out_valid[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL bypass_off: valid0=%b required 0", out_valid[0]);
      end
`endif
      n_checks++;
      if ((out_valid[2:1] !== 2'b11) || (DataOut[2*DW +: DW] !== 8'h11)) begin
         n_fail++;
         $display("FAIL bypass_others: out_valid=%b port2=%h, required 11x/11",
                  out_valid, DataOut[2*DW +: DW]);
      end
      tick();
      n_checks++;
      if ((DataOut[DW-1:0] !== 8'hAA) || (out_valid[0] !== 1'b1) || (Count !== 5'd4)) begin
         n_fail++;
         $display("FAIL bypass_followup: DataOut0=%h valid0=%b Count=%0d, required aa/1/4",
                  DataOut[DW-1:0], out_valid[0], Count);
      end
   endtask

   task automatic test_flush();
      Mode = 1'b0;
      R_Addr = '0;
      flush    = 1'b1;
      in_valid = 1'b1;
      DataIn   = 8'h55;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_ready: in_ready=%b required 0", in_ready);
      end
      tick();
      n_checks++;
      if ((Count !== '0) || (out_valid !== 3'b111)) begin
         n_fail++;
         $display("FAIL flush_count: Count=%0d out_valid=%b, required 0/111", Count, out_valid);
      end
      flush  = 1'b0;
      DataIn = 8'h33;
      tick();
      in_valid = 1'b0;
      tick();
      n_checks++;
      if ((DataOut[DW-1:0] !== 8'h33) || (out_valid !== 3'b111) || (Count !== 5'd1)) begin
         n_fail++;
         $display("FAIL flush_refill: DataOut0=%h out_valid=%b Count=%0d, required 33/111/1",
                  DataOut[DW-1:0], out_valid, Count);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 500; it++) begin
         flush    = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 39) == 0) Mode = ~Mode;
         in_valid = ($urandom_range(0, 3) != 0);
         DataIn   = DW'($urandom);
         for (int k = 0; k < NP; k++) set_addr(k, int'($urandom_range(0, DEPTH-1)));
         #1;
         n_checks++;
         if (in_ready !== m_ready()) begin
            n_fail++;
            $display("FAIL rand_ready it=%0d: in_ready=%b required %b", it, in_ready, m_ready());
         end
         tick();
         n_checks++;
         if ((Count !== (AW+1)'(hist.size())) || (Full !== (hist.size() == DEPTH))) begin
            n_fail++;
            $display("FAIL rand_count it=%0d: Count=%0d Full=%b, required %0d", it, Count, Full, hist.size());
         end
         for (int k = 0; k < NP; k++) begin
            n_checks++;
            if (out_valid[k] !== exp_valid[k]) begin
               n_fail++;
               $display("FAIL rand_valid it=%0d port=%0d: got %b required %b", it, k, out_valid[k], exp_valid[k]);
            end
            if (exp_valid[k]) begin
               n_checks++;
               if (DataOut[k*DW +: DW] !== exp_data[k]) begin
                  n_fail++;
                  $display("FAIL rand_data it=%0d port=%0d: got %h required %h",
                           it, k, DataOut[k*DW +: DW], exp_data[k]);
               end
            end
         end
      end
      flush    = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_reset_midstream();
      test_mode0_fill();
      test_mode1_slide();
      test_partial_window();
      test_bypass();
      test_flush();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/window_line_buffer.md
# window_line_buffer

Parametrised circular sample buffer for the convolution datapath, successor to the two-port addressed buffer. It accepts a stream of samples under a valid/ready handshake and serves `NumPorts` independent registered read ports. It runs in either absolute-address mode (fill-then-hold RAM) or sliding-window mode (overwrite-oldest, taps addressed by age). It feeds the multiply-accumulate array with a full kernel row of taps per cycle and tracks occupancy, so consumers never read unwritten data.

## Interface
- `DataWidth`, 8: sample width.
- `Depth`, 16: entries; power of two, ≥ 2.
- `AddrWidth`, 4: log2(`Depth`).
- `NumPorts`, 3: read ports, ≥ 1.

- `clk`  in  1  clock, rising edge.
- `aclr_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous clear of pointer/occupancy.
- `Mode`  in  1  0 = addressed, 1 = window.
- `in_valid`  in  1  `DataIn` valid.
- `in_ready`  out  1  buffer can accept.
- `DataIn`  in  `DataWidth`  write sample.
- `R_Addr`  in  `NumPorts*AddrWidth`  port k at `[k*AddrWidth +: AddrWidth]`. Mode 0: absolute address. Mode 1: age offset, 0 = newest stored sample.
- `DataOut`  out  `NumPorts*DataWidth`  port k at `[k*DataWidth +: DataWidth]`, registered.
- `out_valid`  out  `NumPorts`  per-port data-valid, registered.
- `Count`  out  `AddrWidth+1`  stored samples, 0..`Depth`.
- `Full`  out  1  `Count == Depth`.

## Operation
- State: `wr_ptr` (`AddrWidth`), `Count`, memory array. The memory is not reset and not cleared by `flush`. `out_valid` guards stale contents.
- `in_ready` is combinational: `!flush && (Mode || !Full)`.
- An accept (`in_valid && in_ready`) writes `mem[wr_ptr] <= DataIn`. `wr_ptr` increments, wrapping from `Depth-1` to 0. `Count` increments, saturating at `Depth`.
- Mode 0: fills sequentially and stops when `Full`. Further writes are refused until `flush` or reset.
- Mode 1: always ready. When `Full`, each accept overwrites the oldest sample and `Count` holds at `Depth`.
- Read address for port k:
  - Mode 0: `R_Addr_k`.
  - Mode 1: `(wr_ptr - 1 - R_Addr_k) mod Depth`, using the pre-write `wr_ptr` of the current cycle.
- Every cycle, `DataOut_k <= mem[addr_k]`. Reads return the pre-write contents of the current cycle (read-before-write), except as modified by `BUFFER_BYPASS_EN`.
- `out_valid_k`:
  - Mode 0: `R_Addr_k < Count`.
  - Mode 1: `R_Addr_k < Count`.
  - Both use the pre-write `Count`.
- `flush`: `wr_ptr <= 0`, `Count <= 0`. A simultaneous write is dropped (`in_ready` is 0). Read registers still update; `out_valid` evaluates against the pre-flush `Count`.
- `Mode` is quasi-static. Changing it does not touch `wr_ptr` or `Count`.

## Timing
- Reset values, asserted immediately on `aclr_n` low, even mid-stream:
  - `wr_ptr` = 0, `Count` = 0, `Full` = 0.
  - `DataOut` = 0, `out_valid` = 0.
- `in_ready` = 1 after reset, since `flush` = 0 and `Full` = 0.
- Read latency: 1 cycle. Addresses presented in cycle n give data and valid after edge n.
- Write-to-read latency (no bypass): a sample accepted at edge n is readable by an address presented in cycle n+1, with data after edge n+1.
- `Count`/`Full` update on the edge of the accept or flush.

## Configuration
- `BUFFER_BYPASS_EN` defined:
  - Mode 0 only: when an accept occurs and `addr_k == wr_ptr`, `DataOut_k <= DataIn` and `out_valid_k <= 1` in the same edge.
  - Write-to-read latency becomes 1 cycle.
- Undefined: strict read-before-write. That port returns stale memory with `out_valid_k` = 0.
- Mode 1 never bypasses.

## Structure
- Package `buffer_pkg`:
  - `MODE_ADDR` = 1'b0 and `MODE_WINDOW` = 1'b1.
  - A function computing the window address from `wr_ptr` and offset.
- Sub-module `buffer_read_port`: address select, valid compare, optional bypass mux, output registers. Instantiated `NumPorts` times by generate.

## Test plan
Defaults unless stated.
1. Reset mid-stream: `aclr_n` low with `Count` = 7 -> immediately `Count` = 0, `Full` = 0, `DataOut` = 0, `out_valid` = 000.
2. Mode 0 fill:
   - Stimulus: write 1..17, then `R_Addr` = {15,5,0}.
   - `Full` after the 16th accept and `in_ready` = 0; the 17th is refused.
   - Next cycle `DataOut` = {16,6,1}, `out_valid` = 111.
3. Mode 1 slide:
   - Stimulus: write 1..20, offsets {2,1,0}.
   - `DataOut` = {18,19,20}, `Count` = 16.
   - Offset 15 -> 5.
4. Mode 1 partial window: after 2 writes (1, 2), offsets {2,1,0} -> `out_valid` = 011, `DataOut` ports 0/1 = 2/1.
5. Bypass in Mode 0:
   - Stimulus: `Count` = 3, write 0xAA while port 0 `R_Addr` = 3.
   - With macro: `DataOut0` = 0xAA, `out_valid0` = 1.
   - Without macro: `out_valid0` = 0. Next cycle a read of 3 returns 0xAA.
6. `flush` with `in_valid` = 1:
   - `in_ready` = 0, write dropped, `Count` = 0.
   - Next accepted 0x33 lands at address 0; a Mode 0 read of address 0 returns 0x33 with valid.
